calc1_port_scheduler: RTL and testbench

//  Front end for the calc1 datapath: shares one ALU between the 4 requester ports.

---
 rtl/calc1_port_scheduler_if.sv | 25 ++
 rtl/calc1_port_scheduler.sv | 174 +++++++++++++++++
 tb/tb_calc1_port_scheduler.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/calc1_port_scheduler_if.sv
// rtl/calc1_port_scheduler_if.sv - ALU request/response channel shared by the calc1 requester ports
interface calc1_port_scheduler_if #(
    parameter int DATA_W = 32
);
    logic              alu_req_valid;
    logic              alu_req_ready;
    logic [3:0]        alu_cmd;
    logic [DATA_W-1:0] alu_op1;
    logic [DATA_W-1:0] alu_op2;
    logic [2:0]        alu_tag;
    logic              alu_rsp_valid;
    logic [2:0]        alu_rsp_tag;
    logic [1:0]        alu_rsp_resp;
    logic [DATA_W-1:0] alu_rsp_data;

    modport master (
        output alu_req_valid, alu_cmd, alu_op1, alu_op2, alu_tag,
        input  alu_req_ready, alu_rsp_valid, alu_rsp_tag, alu_rsp_resp, alu_rsp_data
    );

    modport slave (
        input  alu_req_valid, alu_cmd, alu_op1, alu_op2, alu_tag,
        output alu_req_ready, alu_rsp_valid, alu_rsp_tag, alu_rsp_resp, alu_rsp_data
    );
endinterface

// File: rtl/calc1_port_scheduler.sv
// rtl/calc1_port_scheduler.sv - four-port round-robin front end sharing one calc1 ALU
module calc1_port_scheduler #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                  c_clk,
    input  logic                  reset,
    input  logic [3:0]            req_cmd_in1,
    input  logic [3:0]            req_cmd_in2,
    input  logic [3:0]            req_cmd_in3,
    input  logic [3:0]            req_cmd_in4,
    input  logic [DATA_W-1:0]     req_data_in1,
    input  logic [DATA_W-1:0]     req_data_in2,
    input  logic [DATA_W-1:0]     req_data_in3,
    input  logic [DATA_W-1:0]     req_data_in4,
    output logic [1:0]            out_resp1,
    output logic [1:0]            out_resp2,
    output logic [1:0]            out_resp3,
    output logic [1:0]            out_resp4,
    output logic [DATA_W-1:0]     out_data1,
    output logic [DATA_W-1:0]     out_data2,
    output logic [DATA_W-1:0]     out_data3,
    output logic [DATA_W-1:0]     out_data4,
    calc1_port_scheduler_if.master alu
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {P_IDLE, P_OP2, P_PEND} pstate_t;
    typedef enum logic [1:0] {A_IDLE, A_ISSUE, A_WAIT} astate_t;

    logic [3:0]        cmd_in  [4];
    logic [DATA_W-1:0] data_in [4];
    pstate_t           p_state [4];
    pstate_t           p_next  [4];
    logic              capture [4];
    logic [3:0]        cmd_q   [4];
    logic [DATA_W-1:0] op1_q   [4];
    logic [DATA_W-1:0] op2_q   [4];
    logic [1:0]        resp_q  [4];
    logic [1:0]        resp_d  [4];
    logic [DATA_W-1:0] rdata_q [4];
    logic [DATA_W-1:0] rdata_d [4];
    astate_t           a_state, a_next;
    logic [1:0]        rr_ptr, grant_q, pick;
    logic              pick_ok, gen, rsp_hit, expire, done;
    logic [CNT_W-1:0]  cnt;

    function automatic logic valid_cmd(input logic [3:0] c);
        return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
    endfunction

    assign cmd_in[0]  = req_cmd_in1;
    assign cmd_in[1]  = req_cmd_in2;
    assign cmd_in[2]  = req_cmd_in3;
    assign cmd_in[3]  = req_cmd_in4;
    assign data_in[0] = req_data_in1;
    assign data_in[1] = req_data_in2;
    assign data_in[2] = req_data_in3;
    assign data_in[3] = req_data_in4;
    assign out_resp1  = resp_q[0];
    assign out_resp2  = resp_q[1];
    assign out_resp3  = resp_q[2];
    assign out_resp4  = resp_q[3];
    assign out_data1  = rdata_q[0];
    assign out_data2  = rdata_q[1];
    assign out_data3  = rdata_q[2];
    assign out_data4  = rdata_q[3];

    assign rsp_hit = (a_state == A_WAIT) && alu.alu_rsp_valid && (alu.alu_rsp_tag == alu.alu_tag);
    assign expire  = (a_state == A_WAIT) && (cnt == CNT_W'(TIMEOUT - 1));
    assign done    = rsp_hit || expire;
    assign alu.alu_req_valid = (a_state == A_ISSUE);

    // Walk downward so the pending port closest to the pointer is the last (winning) match.
    always_comb begin
        pick    = rr_ptr;
        pick_ok = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (p_state[rr_ptr + 2'(i)] == P_PEND) begin
                pick    = rr_ptr + 2'(i);
                pick_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            a_state <= A_IDLE;
            for (int i = 0; i < 4; i++) p_state[i] <= P_IDLE;
        end else begin
            a_state <= a_next;
            for (int i = 0; i < 4; i++) p_state[i] <= p_next[i];
        end
    end

    // A port still showing a response this cycle is treated as busy.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            capture[i] = (p_state[i] == P_IDLE) && (cmd_in[i] != 4'd0) && (resp_q[i] == 2'b00);
            p_next[i]  = p_state[i];
            case (p_state[i])
                P_IDLE:  if (capture[i]) p_next[i] = P_OP2;
                P_OP2:   p_next[i] = valid_cmd(cmd_q[i]) ? P_PEND : P_IDLE;
                P_PEND:  if (done && (grant_q == 2'(i))) p_next[i] = P_IDLE;
                default: p_next[i] = P_IDLE;
            endcase
        end
        a_next = a_state;
        case (a_state)
            A_IDLE:  if (pick_ok) a_next = A_ISSUE;
            A_ISSUE: if (alu.alu_req_ready) a_next = A_WAIT;
            A_WAIT:  if (done) a_next = A_IDLE;
            default: a_next = A_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            resp_d[i]  = 2'b00;
            rdata_d[i] = '0;
            if ((p_state[i] == P_OP2) && !valid_cmd(cmd_q[i])) resp_d[i] = 2'b10;
            if (done && (grant_q == 2'(i))) begin
                resp_d[i]  = rsp_hit ? alu.alu_rsp_resp : 2'b10;
                rdata_d[i] = rsp_hit ? alu.alu_rsp_data : '0;
            end
        end
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                cmd_q[i]   <= '0;
                op1_q[i]   <= '0;
                op2_q[i]   <= '0;
                resp_q[i]  <= '0;
                rdata_q[i] <= '0;
            end
            rr_ptr      <= '0;
            grant_q     <= '0;
            gen         <= 1'b0;
            cnt         <= '0;
            alu.alu_cmd <= '0;
            alu.alu_op1 <= '0;
            alu.alu_op2 <= '0;
            alu.alu_tag <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (capture[i]) begin
                    cmd_q[i] <= cmd_in[i];
                    op1_q[i] <= data_in[i];
                end
                if (p_state[i] == P_OP2) op2_q[i] <= data_in[i];
                resp_q[i]  <= resp_d[i];
                rdata_q[i] <= rdata_d[i];
            end
            case (a_state)
                A_IDLE: if (pick_ok) begin
                    grant_q     <= pick;
                    alu.alu_cmd <= cmd_q[pick];
                    alu.alu_op1 <= op1_q[pick];
                    alu.alu_op2 <= op2_q[pick];
                    alu.alu_tag <= {gen, pick};
                end
                A_ISSUE: if (alu.alu_req_ready) begin
                    rr_ptr <= grant_q + 2'd1;
                    gen    <= ~gen;
                    cnt    <= '0;
                end
                A_WAIT:  cnt <= cnt + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_calc1_port_scheduler.sv
// tb/tb_calc1_port_scheduler.sv - directed scoreboard bench for calc1_port_scheduler
module tb_calc1_port_scheduler;
    logic        c_clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  cmd   [4];
    logic [31:0] dat   [4];
    logic [1:0]  oresp [4];
    logic [31:0] odata [4];
    logic        ready_en = 1'b0;
    int          rsp_delay = 3;
    int          rsp_timer = 0;
    logic [2:0]  stub_tag;
    logic [31:0] stub_data;
    logic        exp_gen = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic [33:0] exp_q [4][$];
    logic [2:0]  acc_q [$];

    calc1_port_scheduler_if #(.DATA_W(32)) alu_if ();

    calc1_port_scheduler #(.DATA_W(32), .TIMEOUT(8)) dut (
        .c_clk(c_clk), .reset(reset),
        .req_cmd_in1(cmd[0]), .req_cmd_in2(cmd[1]), .req_cmd_in3(cmd[2]), .req_cmd_in4(cmd[3]),
        .req_data_in1(dat[0]), .req_data_in2(dat[1]), .req_data_in3(dat[2]), .req_data_in4(dat[3]),
        .out_resp1(oresp[0]), .out_resp2(oresp[1]), .out_resp3(oresp[2]), .out_resp4(oresp[3]),
        .out_data1(odata[0]), .out_data2(odata[1]), .out_data3(odata[2]), .out_data4(odata[3]),
        .alu(alu_if.master)
    );

    always #5 c_clk = ~c_clk;
    assign alu_if.alu_req_ready = ready_en;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge c_clk);
        #1;
    endtask

    function automatic logic [31:0] alu_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    // ALU stub: accepts on valid&ready, answers 01/result rsp_delay cycles later (0 = never)
    initial begin
        alu_if.alu_rsp_valid = 1'b0;
        alu_if.alu_rsp_tag   = 3'd0;
        alu_if.alu_rsp_resp  = 2'b00;
        alu_if.alu_rsp_data  = 32'd0;
        forever begin
            @(posedge c_clk);
            #1;
            alu_if.alu_rsp_valid = 1'b0;
            if (rsp_timer > 0) begin
                rsp_timer--;
                if (rsp_timer == 0) begin
                    alu_if.alu_rsp_valid = 1'b1;
                    alu_if.alu_rsp_tag   = stub_tag;
                    alu_if.alu_rsp_resp  = 2'b01;
                    alu_if.alu_rsp_data  = stub_data;
                end
            end
            @(negedge c_clk);
            if (alu_if.alu_req_valid && alu_if.alu_req_ready) begin
                acc_q.push_back(alu_if.alu_tag);
                stub_tag  = alu_if.alu_tag;
                stub_data = alu_model(alu_if.alu_cmd, alu_if.alu_op1, alu_if.alu_op2);
                rsp_timer = rsp_delay;
            end
        end
    end

    always @(negedge c_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (oresp[i] !== 2'b00) begin
                if (exp_q[i].size() == 0)
                    chk($sformatf("unexpected_resp_p%0d", i + 1), {oresp[i], odata[i]}, 64'd0);
                else
                    chk($sformatf("resp_p%0d", i + 1), {oresp[i], odata[i]}, exp_q[i].pop_front());
            end
        end
    end

    task automatic expect_grant(input int port);
        logic [2:0] t;
        for (int k = 0; k < 200 && acc_q.size() == 0; k++) @(negedge c_clk);
        chk($sformatf("grant_seen_p%0d", port), acc_q.size() != 0, 1);
        if (acc_q.size() != 0) begin
            t = acc_q.pop_front();
            chk($sformatf("grant_tag_p%0d", port), t, {exp_gen, 2'(port - 1)});
            exp_gen = ~exp_gen;
        end
    endtask

    task automatic send(input int port, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        cmd[port-1] = c;
        dat[port-1] = a;
        step(1);
        cmd[port-1] = 4'd0;
        dat[port-1] = b;
        step(1);
        dat[port-1] = 32'd0;
    endtask

    task automatic send_multi(input logic [3:0] m, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 4; i++) if (m[i]) begin cmd[i] = c; dat[i] = a + 32'(i); end
        step(1);
        for (int i = 0; i < 4; i++) if (m[i]) begin cmd[i] = 4'd0; dat[i] = b + 32'(i); end
        step(1);
        for (int i = 0; i < 4; i++) dat[i] = 32'd0;
    endtask

    task automatic push(input int port, input logic [1:0] r, input logic [31:0] d);
        exp_q[port-1].push_back({r, d});
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin cmd[i] = 4'd0; dat[i] = 32'd0; end
        step(2);
        chk("rst_valid", alu_if.alu_req_valid, 0);
        chk("rst_payload", {alu_if.alu_cmd, alu_if.alu_op1, alu_if.alu_op2, alu_if.alu_tag}, 0);
        chk("rst_outs", {oresp[0], oresp[1], oresp[2], oresp[3], odata[0] | odata[3]}, 0);
        reset = 1'b0;
        step(1);

        // single add on port1, response 3 cycles after accept
        ready_en = 1'b1; rsp_delay = 3;
        push(1, 2'b01, 32'd12);
        send(1, 4'd1, 32'd5, 32'd7);
        step(5);
        chk("p1_add_resp", {oresp[0], odata[0]}, {2'b01, 32'd12});
        step(1);
        chk("p1_one_cycle", {oresp[0], odata[0]}, 0);
        expect_grant(1);

        // asynchronous reset while a request is held and an invalid response is showing
        ready_en = 1'b0;
        step(1);
        cmd[1] = 4'd1; dat[1] = 32'd1;
        step(1);
        cmd[1] = 4'd0; cmd[2] = 4'd7; dat[2] = 32'd9;
        step(1);
        cmd[2] = 4'd0; dat[1] = 32'd0; dat[2] = 32'd0;
        step(1);
        chk("pre_rst_inv_p3", oresp[2], 2'b10);
        chk("pre_rst_valid", alu_if.alu_req_valid, 1);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_resp", oresp[2], 0);
        chk("async_rst_valid", alu_if.alu_req_valid, 0);
        chk("async_rst_payload", {alu_if.alu_cmd, alu_if.alu_op1, alu_if.alu_tag}, 0);
        step(1);
        reset = 1'b0; exp_gen = 1'b0;
        step(2);

        // all four ports at once: round robin from port1
        ready_en = 1'b1; rsp_delay = 2;
        for (int p = 1; p <= 4; p++) push(p, 2'b01, 32'd100);
        send_multi(4'b1111, 4'd2, 32'd150, 32'd50);
        for (int p = 1; p <= 4; p++) expect_grant(p);
        step(6);

        // ports 1 and 3 together with pointer back at port1
        push(1, 2'b01, 32'd12);
        push(3, 2'b01, 32'd80);
        send_multi(4'b0101, 4'd5, 32'd3, 32'd2);
        expect_grant(1);
        expect_grant(3);
        step(6);

        // invalid command on port2: error at N+2, never reaches the ALU
        rsp_delay = 3;
        push(2, 2'b10, 32'd0);
        send(2, 4'h3, 32'd44, 32'd55);
        chk("inv_p2_n2", {oresp[1], odata[1]}, {2'b10, 32'd0});
        step(3);
        chk("inv_no_issue", acc_q.size(), 0);
        chk("inv_no_valid", alu_if.alu_req_valid, 0);

        // invalid on port4 lands in the same cycle as the ALU response for port1
        push(1, 2'b01, 32'd15);
        push(4, 2'b10, 32'd0);
        send(1, 4'd1, 32'd7, 32'd8);
        step(3);
        send(4, 4'hF, 32'd1, 32'd2);
        chk("coincide_p1", {oresp[0], odata[0]}, {2'b01, 32'd15});
        chk("coincide_p4", {oresp[3], odata[3]}, {2'b10, 32'd0});
        expect_grant(1);
        step(3);

        // ready held low 5 cycles, then timeout with a late response
        ready_en = 1'b0; rsp_delay = 12;
        push(1, 2'b10, 32'd0);
        send(1, 4'd5, 32'd3, 32'd4);
        step(1);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall_hold_%0d", k),
                {alu_if.alu_req_valid, alu_if.alu_cmd, alu_if.alu_op1, alu_if.alu_op2, alu_if.alu_tag},
                {1'b1, 4'd5, 32'd3, 32'd4, exp_gen, 2'd0});
            step(1);
        end
        ready_en = 1'b1;
        step(8);
        chk("timeout_not_early", oresp[0], 0);
        step(1);
        chk("timeout_resp", {oresp[0], odata[0]}, {2'b10, 32'd0});
        expect_grant(1);
        step(6);

        // busy-port commands ignored, including during the response cycle
        rsp_delay = 3;
        push(2, 2'b01, 32'd5);
        send(2, 4'd1, 32'd2, 32'd3);
        step(1);
        cmd[1] = 4'd2; dat[1] = 32'd100;
        step(1);
        cmd[1] = 4'd0; dat[1] = 32'd0;
        step(3);
        chk("busy_first_resp", {oresp[1], odata[1]}, {2'b01, 32'd5});
        cmd[1] = 4'd6; dat[1] = 32'd99;
        step(1);
        push(2, 2'b01, 32'd30);
        send(2, 4'd1, 32'd10, 32'd20);
        expect_grant(2);
        expect_grant(2);
        step(10);

        for (int i = 0; i < 4; i++) chk($sformatf("drain_p%0d", i + 1), exp_q[i].size(), 0);
        chk("drain_grants", acc_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end
endmodule
